// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, well-known register indices
// and the exception status codes carried on the exception write port.
package cpu_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO    = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_RSTATUS = 5'd30;
  localparam logic [REG_IDX_W-1:0] REG_RA      = 5'd31;

  typedef enum logic [DATA_W-1:0] {
    EXC_NONE = 32'd0,
    EXC_ADD  = 32'd1,
    EXC_ADDI = 32'd2,
    EXC_SUB  = 32'd3,
    EXC_MUL  = 32'd4,
    EXC_DIV  = 32'd5
  } exc_code_e;

endpackage

// File: rtl/regfile_wb_if.sv
// Writeback/decode side of the register file: write strobes, exception write
// and the two combinational read ports.
interface regfile_wb_if;
  import cpu_pkg::*;

  // No valid/ready pair here: each strobe qualifies exactly one cycle, so a
  // strobe held high for N cycles performs N writes; reads are combinational.
  logic                 ctrl_writeEnable;
  logic [REG_IDX_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0]    data_writeReg;
  logic                 ctrl_excEnable;
  logic [DATA_W-1:0]    data_exc;
  logic [REG_IDX_W-1:0] ctrl_readRegA;
  logic [REG_IDX_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0]    data_readRegA;
  logic [DATA_W-1:0]    data_readRegB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_excEnable, data_exc,
    output ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_excEnable, data_exc,
    input  ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB
  );

endinterface

// File: rtl/regfile_reg.sv
// One register-file entry: W-bit register with asynchronous clear and load enable.
module regfile_reg
  import cpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// 32x32 register file with r0 hardwired to zero and an exception port into $rstatus.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_wb
  import cpu_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int STATUS_REG = 30
) (
  input  logic         clock,
  input  logic         reset,
  regfile_wb_if.slave  rf
);

  logic [NUM_REGS-1:1] wr_en;
  logic [DATA_W-1:0]   wr_data [1:NUM_REGS-1];
  logic [DATA_W-1:0]   q       [NUM_REGS];
  logic [REG_IDX_W-1:0] rd_idx  [2];
  logic [DATA_W-1:0]    rd_data [2];

  // One-hot write decode; the exception port overrides the normal port at STATUS_REG.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      wr_en[i]   = rf.ctrl_writeEnable && (rf.ctrl_writeReg == REG_IDX_W'(i));
      wr_data[i] = rf.data_writeReg;
      if (i == STATUS_REG && rf.ctrl_excEnable) begin
        wr_en[i]   = 1'b1;
        wr_data[i] = rf.data_exc;
      end
    end
  end

  assign q[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    regfile_reg #(.W(DATA_W)) u_reg (
      .clock (clock),
      .reset (reset),
      .en    (wr_en[g]),
      .d     (wr_data[g]),
      .q     (q[g])
    );
  end

  assign rd_idx[0] = rf.ctrl_readRegA;
  assign rd_idx[1] = rf.ctrl_readRegB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = q[rd_idx[p]];
`ifdef REGFILE_BYPASS_EN
      // wr_en has no entry for index 0, so r0 can never be bypassed.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_en[i] && rd_idx[p] == REG_IDX_W'(i)) begin
          rd_data[p] = wr_data[i];
        end
      end
`endif
      if (reset) begin
        rd_data[p] = '0;
      end
    end
  end

  assign rf.data_readRegA = rd_data[0];
  assign rf.data_readRegB = rd_data[1];

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Processor register file: 32 registers of 32 bits, receiving the write stream the writeback stage produces and serving the two operand reads of the decode stage. Register 0 is hardwired to zero. A dedicated exception port writes $rstatus (register 30) on ALU overflow, in parallel with the normal write port. An optional same-cycle write-to-read bypass makes a value written this cycle visible to decode at once.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; fixes the index width at 5.
- DATA_W, 32, register width in bits.
- STATUS_REG, 30, index written by the exception port.

Ports:
- clock  in  1  single clock; all register updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- ctrl_writeEnable  in  1  normal write strobe, from writeback.
- ctrl_writeReg  in  5  normal write index.
- data_writeReg  in  32  normal write data.
- ctrl_excEnable  in  1  exception write strobe; writes STATUS_REG.
- data_exc  in  32  exception status code.
- ctrl_readRegA  in  5  read port A index.
- ctrl_readRegB  in  5  read port B index.
- data_readRegA  out  32  read port A data.
- data_readRegB  out  32  read port B data.

## Operation
- Storage: regs[1..31], each 32 bits. regs[0] is not stored and always reads 0.
- Normal write:
  - When ctrl_writeEnable=1 and ctrl_writeReg≠0, regs[ctrl_writeReg] ← data_writeReg on the rising edge.
  - A write to index 0 is silently dropped.
- Exception write: when ctrl_excEnable=1, regs[STATUS_REG] ← data_exc on the rising edge.
- Both strobes in the same cycle:
  - Different targets: both writes happen.
  - Both target STATUS_REG: the exception port wins and data_writeReg is discarded.
- Reads:
  - Combinational; data_readRegX = regs[ctrl_readRegX].
  - Index 0 returns 0.
  - Ports A and B are independent and may select the same index.
- Bypass: behaviour with and without is defined under Configuration.
- While reset=1:
  - Both read outputs are 0.
  - Writes are ignored.
- Reset arriving mid-operation clears all registers immediately, with no clock edge needed. A write strobed in the cycle reset deasserts takes effect on the next rising edge.

## Timing
- Write latency: the write commits at the rising edge closing the cycle in which the strobe is high.
- Without bypass, new data is readable starting the following cycle.
- Read latency: 0 cycles (combinational from index to data).
- No handshake: strobes are single-cycle qualifiers; holding a strobe for N cycles performs N writes.
- Reset values: regs[1..31]=0, data_readRegA=0, data_readRegB=0.
- No wrap-around or full/empty conditions. All indices 0..31 are legal.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose index equals a write target committing in the same cycle returns the incoming data, with no wait for the edge.
  - Exception-port data takes priority over normal-port data when both target STATUS_REG.
  - Index 0 is never bypassed.
- Undefined:
  - Reads always return the stored value, i.e. the old value during a write cycle.
  - The pipeline must stall or forward externally.

## Structure
- Shared package cpu_pkg holds:
  - REG_ZERO=5'd0, REG_RSTATUS=5'd30, REG_RA=5'd31.
  - DATA_W and the register index width.
  - Exception status codes written on data_exc: add=1, addi=2, sub=3, mul=4, div=5.
- Sub-module regfile_reg: one DATA_W-bit register with async clear and write enable, instantiated 31 times via generate.
- Top level contains:
  - Write decode: one-hot enable per register, with exception priority at index 30.
  - The two read multiplexers.
  - The bypass compare logic under the macro.

## Test plan
- Reset then read: assert reset, read indices 0..31 on both ports → all 0.
- Basic write: write r5 ← 0xDEADBEEF, next cycle read A=5 and B=5 → both 0xDEADBEEF.
- r0 write: write r0 ← 0x12345678, next cycle read A=0 → 0.
- Exception priority at r30: in one cycle, normal write r30 ← 0x0000AAAA and exception write data_exc=1.
  - Next cycle read r30 → 0x00000001.
  - Then a normal write r7 ← 9 together with an exception write (data_exc=3): both land, r7=9 and r30=3.
- Same-cycle read of the written register: write r12 ← 0x55, read A=12 in the same cycle.
  - With REGFILE_BYPASS_EN: 0x55.
  - Without it: the prior value, e.g. 0.
  - Next cycle: 0x55 in both builds.
- Async reset mid-stream: fill r1..r31 with their index values, pulse reset between clock edges → all reads 0 before the next edge. A write strobed in the first cycle after release lands normally.
